// File: rtl/fft_pkg.sv
// Shared encodings and twiddle helpers for the radix-2 FFT butterfly scheduler.
package fft_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned TW_TABLE_DEPTH = 8;
  localparam int unsigned TW_IDX_W       = 3;

  // Left shift applied to the in-group position to index the W_8 spin table.
  function automatic logic [2:0] tw_shift(input int unsigned log2n, input logic [1:0] s);
    return 3'(2 * $clog2(TW_TABLE_DEPTH) - log2n - 1) - {1'b0, s};
  endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational map from (stage, butterfly index) to operand addresses and twiddle index.
module fft_bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned  LOG2N  = 3,
  localparam int unsigned ADDR_W = LOG2N,
  localparam int unsigned J_W    = LOG2N - 1
) (
  input  logic [1:0]          stage,
  input  logic [J_W-1:0]      j,
  output logic [ADDR_W-1:0]   addr_a,
  output logic [ADDR_W-1:0]   addr_b,
  output logic [TW_IDX_W-1:0] tw_idx
);

  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;
  logic [2:0]        span_sh;

  always_comb begin
    half    = ADDR_W'(1) << stage;
    pos     = ADDR_W'(j) & (half - ADDR_W'(1));
    grp     = ADDR_W'(j) >> stage;
    span_sh = {1'b0, stage} + 3'd1;
    addr_a  = (grp << span_sh) | pos;
    addr_b  = addr_a + half;
    tw_idx  = TW_IDX_W'(pos) << tw_shift(LOG2N, stage);
  end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Issues the butterflies of one in-place radix-2 DIT FFT, draining the datapath between stages.
module fft_bfly_scheduler
  import fft_pkg::*;
#(
  parameter int unsigned  LOG2N    = 3,
  parameter int unsigned  BFLY_LAT = 2,
  localparam int unsigned ADDR_W   = LOG2N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                bf_valid,
  input  logic                bf_ready,
  output logic [ADDR_W-1:0]   addr_a,
  output logic [ADDR_W-1:0]   addr_b,
  output logic [TW_IDX_W-1:0] tw_idx,
  output logic [1:0]          stage
);

  localparam int unsigned J_W        = LOG2N - 1;
  localparam int unsigned CNT_W      = 4;
  localparam logic [J_W-1:0] J_LAST  = '1;
  localparam logic [1:0] LAST_STAGE  = 2'(LOG2N - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(BFLY_LAT);

  logic [1:0]       state, state_nxt;
  logic [J_W-1:0]   j, j_nxt;
  logic [1:0]       stage_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_nxt, done_nxt, valid_nxt;

  logic [ADDR_W-1:0]   gen_a, gen_b;
  logic [TW_IDX_W-1:0] gen_tw;

  // Addresses are generated from the next (stage, j) so they land registered with bf_valid.
  fft_bfly_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .stage  (stage_nxt),
    .j      (j_nxt),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_comb begin
    state_nxt = state;
    j_nxt     = j;
    stage_nxt = stage;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    valid_nxt = bf_valid;
    case (state)
      ST_IDLE: begin
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
        if (start) begin
          state_nxt = ST_ISSUE;
          j_nxt     = '0;
          stage_nxt = '0;
          busy_nxt  = 1'b1;
          valid_nxt = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (bf_ready) begin
          if (j == J_LAST) begin
            state_nxt = ST_DRAIN;
            j_nxt     = '0;
            cnt_nxt   = LAT_LOAD;
            valid_nxt = 1'b0;
          end else begin
            j_nxt = j + J_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt == CNT_W'(1)) begin
          cnt_nxt = '0;
          if (stage == LAST_STAGE) begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_ISSUE;
            stage_nxt = stage + 2'd1;
            j_nxt     = '0;
            valid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        stage_nxt = '0;
        j_nxt     = '0;
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      j        <= '0;
      stage    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_valid <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_idx   <= '0;
    end else begin
      state    <= state_nxt;
      j        <= j_nxt;
      stage    <= stage_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      bf_valid <= valid_nxt;
      // Holding the payload when nothing is presented keeps it stable through stalls and idle.
      if (valid_nxt) begin
        addr_a <= gen_a;
        addr_b <= gen_b;
        tw_idx <= gen_tw;
      end
    end
  end

endmodule
